fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline buffer.
- Holds the fetch PC and issues in-order reads to instruction memory over a request/grant/response handshake.
- Buffers returned instructions in a small queue and presents IF_PC / IF_INST / IF_FLUSH to IF/ID.
- Honours the if_id_Write stall and discards wrong-path instructions on a branch/jump redirect from ID/EX.

Parameters:
- RESET_PC, 32'd0, fetch address after reset.
- PC_STEP, 4, PC increment per fetched instruction (byte-addressed).
- QDEPTH, 4, queue depth, also the in-flight request limit; power of two, at least 2.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_id_Write  in  1  IF/ID accepts this cycle; 0 means stall.
- redirect  in  1  taken branch/jump; restart fetch at redirect_target.
- redirect_target  in  32  new fetch PC.
- im_req  out  1  memory read request.
- im_addr  out  32  read address (current fetch PC).
- im_gnt  in  1  request accepted this cycle.
- im_rvalid  in  1  read data valid; responses return in request order.
- im_rdata  in  32  instruction word.
- IF_PC  out  32  PC of the presented instruction.
- IF_INST  out  32  presented instruction.
- IF_FLUSH  out  1  IF/ID must load a bubble.

Behaviour:
- State: fetch_pc; instruction queue of {pc, inst}, occupancy occ; in-flight PC FIFO of depth QDEPTH; counters live and stale, where live + stale = in-flight count.
- Reset (asynchronous, immediate, also mid-operation):
  - fetch_pc = RESET_PC; queue and in-flight FIFO empty; live = stale = 0.
  - Outputs: im_req = 0, im_addr = RESET_PC, IF_PC = 0, IF_INST = 0, IF_FLUSH = 1.
  - Responses arriving after reset release are ignored while the in-flight count is 0.
- Issue:
  - im_req = !redirect && (occ + live + stale < QDEPTH); im_addr = fetch_pc.
  - On im_req && im_gnt: push fetch_pc into the in-flight FIFO, live++, fetch_pc += PC_STEP (mod 2^32, wraps silently).
  - im_req holds with a stable address until granted.
- Response (im_rvalid):
  - Every response pops the in-flight FIFO.
  - If stale > 0: discard the data, stale--.
  - Otherwise: push {popped pc, im_rdata} into the queue, live--.
  - im_rvalid with zero in flight is ignored.
- Present (combinational from queue head):
  - Queue non-empty: IF_PC / IF_INST = head entry.
  - Queue empty: IF_PC = 0, IF_INST = 0 (NOP).
  - IF_FLUSH = redirect || queue empty.
- Dequeue: pop the head when if_id_Write && !redirect && queue non-empty. A push and a pop in the same cycle are both honoured, and occ is unchanged.
- Redirect, single cycle, takes priority over everything above:
  - fetch_pc <= redirect_target; queue cleared; no request issued this cycle.
  - A response arriving in this cycle is discarded; the in-flight FIFO still pops.
  - stale <= stale + live, less one if a response arrived this cycle; live <= 0.
  - First request to the new target goes out the next cycle if credit allows.
- Credit rule guarantees the queue never overflows; no full-queue push path exists.
- Latency:
  - Response arriving in cycle N is presented in cycle N+1.
  - With a 1-cycle memory and continuous if_id_Write, throughput is one instruction per cycle after startup.
- Stall: while if_id_Write = 0 the head holds and IF_PC / IF_INST stay stable. Fetching continues until occ + in-flight reaches QDEPTH, then im_req drops.

Test Plan:
- Reset release, memory granting every cycle with 1-cycle rdata = address, if_id_Write = 1 → im_addr 0, 4, 8, …; IF_PC / IF_INST present 0 / 0 then 4 / 4 in consecutive cycles; IF_FLUSH = 0 once the stream starts.
- Hold if_id_Write = 0 for 10 cycles → exactly QDEPTH = 4 grants, then im_req = 0; IF_PC stays at the head value. Release → PCs 0, 4, 8, 12 emerge in order with no gap and no duplicate.
- 3-cycle memory latency, 2 requests in flight, redirect to 0x100 → IF_FLUSH = 1 that cycle; both old responses are discarded; the next im_addr is 0x100; the first presented IF_PC is 0x100.
- Redirect in the same cycle as im_rvalid → that response is dropped; stale counts the remaining in-flight requests; no stale instruction ever reaches IF_INST.
- Assert rst mid-stream with the queue full → outputs go to reset values immediately; after release im_addr = RESET_PC.
- fetch_pc = 0xFFFFFFFC granted → next im_addr = 0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues in-order reads to instruction memory, buffers the
// returned words and presents them to IF/ID, dropping wrong-path responses after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_id_Write,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INST,
  output logic        IF_FLUSH
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW+1:0] QDEPTH_W = (CW+2)'(QDEPTH);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   q_pc_r   [QDEPTH];
  logic [31:0]   q_inst_r [QDEPTH];
  logic [PW-1:0] q_head_r;
  logic [PW-1:0] q_tail_r;
  logic [CW-1:0] occ_r;
  logic [31:0]   f_pc_r   [QDEPTH];
  logic [PW-1:0] f_rd_r;
  logic [PW-1:0] f_wr_r;
  logic [CW-1:0] live_r;
  logic [CW-1:0] stale_r;

  logic [CW-1:0] in_flight_s;
  logic [CW+1:0] credit_sum_s;
  logic          issue_s;
  logic          resp_s;
  logic          stale_hit_s;
  logic          live_hit_s;
  logic          push_s;
  logic          pop_s;
  logic          q_empty_s;
  logic [31:0]   resp_pc_s;

  // Queue entries plus every outstanding request share one credit pool, so the queue cannot overflow.
  assign in_flight_s  = live_r + stale_r;
  assign credit_sum_s = {2'b00, occ_r} + {2'b00, in_flight_s};
  assign im_req       = !rst && !redirect && (credit_sum_s < QDEPTH_W);
  assign im_addr      = fetch_pc_r;

  assign issue_s     = im_req && im_gnt;
  assign resp_s      = im_rvalid && (in_flight_s != {CW{1'b0}});
  assign stale_hit_s = resp_s && (stale_r != {CW{1'b0}});
  assign live_hit_s  = resp_s && (stale_r == {CW{1'b0}});
  assign push_s      = live_hit_s && !redirect;
  assign q_empty_s   = (occ_r == {CW{1'b0}});
  assign pop_s       = if_id_Write && !redirect && !q_empty_s;
  assign resp_pc_s   = f_pc_r[f_rd_r];

  assign IF_PC    = q_empty_s ? 32'd0 : q_pc_r[q_head_r];
  assign IF_INST  = q_empty_s ? 32'd0 : q_inst_r[q_head_r];
  assign IF_FLUSH = redirect || q_empty_s;

  // Fetch PC, pointers and live/stale accounting; a redirect turns all live requests stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      q_head_r   <= {PW{1'b0}};
      q_tail_r   <= {PW{1'b0}};
      occ_r      <= {CW{1'b0}};
      f_rd_r     <= {PW{1'b0}};
      f_wr_r     <= {PW{1'b0}};
      live_r     <= {CW{1'b0}};
      stale_r    <= {CW{1'b0}};
    end else if (redirect) begin
      fetch_pc_r <= redirect_target;
      q_head_r   <= {PW{1'b0}};
      q_tail_r   <= {PW{1'b0}};
      occ_r      <= {CW{1'b0}};
      live_r     <= {CW{1'b0}};
      stale_r    <= stale_r + live_r - CW'(resp_s);
      if (resp_s) begin
        f_rd_r <= f_rd_r + PW'(1);
      end
    end else begin
      if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
        f_wr_r     <= f_wr_r + PW'(1);
      end
      if (resp_s) begin
        f_rd_r <= f_rd_r + PW'(1);
      end
      if (push_s) begin
        q_tail_r <= q_tail_r + PW'(1);
      end
      if (pop_s) begin
        q_head_r <= q_head_r + PW'(1);
      end
      occ_r   <= occ_r + CW'(push_s) - CW'(pop_s);
      live_r  <= live_r + CW'(issue_s) - CW'(live_hit_s);
      stale_r <= stale_r - CW'(stale_hit_s);
    end
  end

  // Storage arrays need no reset: occupancy and the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      f_pc_r[f_wr_r] <= fetch_pc_r;
    end
    if (push_s) begin
      q_pc_r[q_tail_r]   <= resp_pc_s;
      q_inst_r[q_tail_r] <= im_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model with variable latency drives the
// DUT, and a queue-level reference model predicts every output each cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_id_Write = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'd0;
  logic [31:0] IF_PC;
  logic [31:0] IF_INST;
  logic        IF_FLUSH;

  fetch_unit #(.RESET_PC(32'd0), .PC_STEP(32'd4), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .if_id_Write(if_id_Write), .redirect(redirect),
    .redirect_target(redirect_target), .im_req(im_req), .im_addr(im_addr),
    .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .IF_PC(IF_PC), .IF_INST(IF_INST), .IF_FLUSH(IF_FLUSH)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] DKEY = 32'h1357_9BDF;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  // reference model: presented queue, in-flight list with per-request wrong-path tags
  ent_t        m_q[$];
  logic [31:0] fl_pc[$];
  bit          fl_stale[$];
  logic [31:0] m_pc = 32'd0;

  // memory model
  mreq_t mem_q[$];
  int    cyc = 0;
  int    last_due = 0;

  // knobs
  int p_gnt = 100, p_rv = 100, p_ifw = 100, p_redir = 0, p_spur = 0;
  int lat_min = 1, lat_max = 1;
  bit force_redir = 1'b0;
  logic [31:0] force_target = 32'd0;
  int grants = 0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_im_req"}, {31'd0, im_req}, 32'd0);
    check_eq({tag, "_im_addr"}, im_addr, 32'd0);
    check_eq({tag, "_IF_PC"}, IF_PC, 32'd0);
    check_eq({tag, "_IF_INST"}, IF_INST, 32'd0);
    check_eq({tag, "_IF_FLUSH"}, {31'd0, IF_FLUSH}, 32'd1);
  endtask

  task automatic run_cycle();
    bit          rv_mem, rv_spur, exp_req, resp, st;
    logic [31:0] rpc, old_pc;
    int          due;
    @(negedge clk);
    if_id_Write     = ($urandom_range(99) < p_ifw);
    redirect        = force_redir || ($urandom_range(999) < p_redir);
    redirect_target = force_redir ? force_target : ($urandom & 32'hFFFF_FFFC);
    force_redir     = 1'b0;
    im_gnt          = ($urandom_range(99) < p_gnt);
    rv_mem  = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rv);
    rv_spur = (mem_q.size() == 0) && ($urandom_range(99) < p_spur);
    im_rvalid = rv_mem || rv_spur;
    im_rdata  = rv_mem ? (mem_q[0].addr ^ DKEY) : $urandom;
    #1;
    exp_req = !redirect && ((m_q.size() + fl_pc.size()) < 4);
    check_eq("im_req", {31'd0, im_req}, {31'd0, exp_req});
    check_eq("im_addr", im_addr, m_pc);
    check_eq("IF_PC", IF_PC, (m_q.size() > 0) ? m_q[0].pc : 32'd0);
    check_eq("IF_INST", IF_INST, (m_q.size() > 0) ? m_q[0].inst : 32'd0);
    check_eq("IF_FLUSH", {31'd0, IF_FLUSH}, {31'd0, (redirect || (m_q.size() == 0))});
    if (im_req && im_gnt) grants++;
    @(posedge clk);
    old_pc = m_pc;
    resp = im_rvalid && (fl_pc.size() > 0);
    st = 1'b0;
    rpc = 32'd0;
    if (resp) begin
      rpc = fl_pc.pop_front();
      st  = fl_stale.pop_front();
    end
    if (redirect) begin
      m_q.delete();
      foreach (fl_stale[i]) fl_stale[i] = 1'b1;
      m_pc = redirect_target;
    end else begin
      if (if_id_Write && (m_q.size() > 0)) void'(m_q.pop_front());
      if (resp && !st) m_q.push_back('{pc: rpc, inst: im_rdata});
      if (exp_req && im_gnt) begin
        fl_pc.push_back(m_pc);
        fl_stale.push_back(1'b0);
        m_pc = m_pc + 32'd4;
      end
    end
    if (rv_mem) void'(mem_q.pop_front());
    if (exp_req && im_gnt) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: old_pc, due: due});
    end
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must change before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    redirect  = 1'b0;
    im_gnt    = 1'b0;
    im_rvalid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    cyc++;
    m_q.delete();
    fl_pc.delete();
    fl_stale.delete();
    m_pc = 32'd0;
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst");
    rst = 1'b0;

    // continuous stream, 1-cycle memory
    run_n(12);

    // redirect to 0, then stall: exactly four grants before im_req drops
    p_ifw = 0;
    force_redir = 1'b1;
    force_target = 32'd0;
    grants = 0;
    run_n(11);
    check_eq("stall_grants", grants, 32'd4);
    p_ifw = 100;
    run_n(8);

    // 3-cycle memory, redirect to 0x100 with requests outstanding
    lat_min = 3; lat_max = 3;
    run_n(6);
    force_redir = 1'b1;
    force_target = 32'h0000_0100;
    run_n(14);

    // address wrap
    lat_min = 1; lat_max = 1;
    force_redir = 1'b1;
    force_target = 32'hFFFF_FFF8;
    run_n(8);

    // randomized traffic
    p_spur = 5;
    for (int blk = 0; blk < 12; blk++) begin
      p_gnt   = $urandom_range(100, 30);
      p_rv    = $urandom_range(100, 30);
      p_ifw   = $urandom_range(100, 20);
      p_redir = $urandom_range(60, 0);
      lat_min = $urandom_range(2, 1);
      lat_max = lat_min + $urandom_range(2, 0);
      run_n(200);
    end

    // fill the queue under stall, then reset mid-stream with responses still pending
    p_gnt = 100; p_rv = 100; p_ifw = 0; p_redir = 0; p_spur = 0;
    lat_min = 2; lat_max = 2;
    run_n(10);
    do_reset();
    p_ifw = 100;
    run_n(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
